verificador_sequencia_param: RTL and testbench

Parametrised successor of the game datapath's sequence/compare path: holds a loadable note sequence, presents it round by round, captures one-hot button plays on press edges, and judges them against the stored sequence. It also keeps score, counts errors and applies a per-play timeout. It sits between the button synchroniser and the top-level game controller. It adds three things: a writable sequence memory instead of fixed ROMs, a generic button count and depth, and a strict/tolerant error mode.

---
 rtl/verificador_sequencia_param_if.sv | 42 ++++
 rtl/verificador_sequencia_param.sv | 231 +++++++++++++++++++++++
 tb/tb_verificador_sequencia_param.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/verificador_sequencia_param_if.sv
// Bus between the game controller and the sequence checker.
// The controller uses the master modport: it loads the sequence, starts the
// game, selects the error mode and forwards the synchronised button levels.
// The checker uses the slave modport and returns the notes being presented,
// the verdict pulses, the score and the end-of-game levels.
interface verificador_sequencia_param_if #(
  parameter int N_BOTOES = 7,
  parameter int AW       = 4
);
  // Controller -> checker
  logic                carrega;
  logic [AW-1:0]       carrega_addr;
  logic [N_BOTOES-1:0] carrega_dado;
  logic                iniciar;
  logic                modo;
  logic [N_BOTOES-1:0] botoes;

  // Checker -> controller
  logic [N_BOTOES-1:0] nota_esperada;
  logic                mostra;
  logic                acertou;
  logic                errou;
  logic                timeout;
  logic [AW-1:0]       rodada;
  logic [3:0]          erros;
  logic [7:0]          pontos;
  logic                ganhou;
  logic                perdeu;
  logic [2:0]          db_estado;

  modport master (
    output carrega, carrega_addr, carrega_dado, iniciar, modo, botoes,
    input  nota_esperada, mostra, acertou, errou, timeout,
           rodada, erros, pontos, ganhou, perdeu, db_estado
  );

  modport slave (
    input  carrega, carrega_addr, carrega_dado, iniciar, modo, botoes,
    output nota_esperada, mostra, acertou, errou, timeout,
           rodada, erros, pontos, ganhou, perdeu, db_estado
  );
endinterface

// File: rtl/verificador_sequencia_param.sv
// Sequence checker for the memory game.
// Holds a writable note sequence, presents it round by round, captures one-hot
// button plays on press edges and judges them against the stored notes. It
// also keeps the score and the error count, and supports a strict mode (the
// first error loses) and a tolerant mode (retry, up to MAX_ERROS errors).
// Optional build macro: SEQ_TIMEOUT_EN -- when defined, each play must arrive
// within M_TIMEOUT cycles or it counts as a wrong play. When undefined, the
// block waits indefinitely for a play and timeout stays 0.
module verificador_sequencia_param #(
  parameter int N_BOTOES  = 7,
  parameter int PROF      = 16,
  parameter int T_NOTA    = 500,
  parameter int M_TIMEOUT = 60000,
  parameter int MAX_ERROS = 3
) (
  input  logic clock,
  input  logic reset,
  verificador_sequencia_param_if.slave seq_if
);

  localparam int AW = (PROF > 1) ? $clog2(PROF) : 1;
  localparam int NW = (T_NOTA > 1) ? $clog2(T_NOTA) : 1;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    MOSTRA     = 3'd1,
    ESPERA     = 3'd2,
    AVALIA     = 3'd3,
    FIM_RODADA = 3'd4,
    GANHOU     = 3'd5,
    PERDEU     = 3'd6
  } estado_t;

  // Score helpers: additions saturate at 255, the penalty floors at 0.
  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  function automatic logic [7:0] floor_sub2(input logic [7:0] a);
    return (a < 8'd2) ? 8'd0 : a - 8'd2;
  endfunction

  estado_t             state_q;
  logic [AW-1:0]       idx_q, idx_d;
  logic [AW-1:0]       rodada_q;
  logic [NW-1:0]       nota_cnt_q;
  logic [N_BOTOES-1:0] mem_q [PROF];
  logic [N_BOTOES-1:0] rd_q;
  logic [N_BOTOES-1:0] jogada_q;
  logic                prev_or_q;
  logic [3:0]          erros_q;
  logic [7:0]          pontos_q;
  logic                mostra_q, acertou_q, errou_q, timeout_q;
  logic                ganhou_q, perdeu_q;

  logic any_btn, press, play_ok, jogada_ok, nota_fim, ultimo, to_fire, wr_en;

  assign any_btn   = |seq_if.botoes;
  // A play is only taken on the rising edge of "any button", and only while
  // waiting for one; levels held across states never retrigger.
  assign press     = (state_q == ESPERA) && any_btn && !prev_or_q;
  assign play_ok   = (seq_if.botoes == rd_q);
  // A zero play (timeout) is never correct, even against an empty memory word.
  assign jogada_ok = (jogada_q == rd_q) && (|jogada_q);
  assign nota_fim  = (nota_cnt_q == NW'(T_NOTA - 1));
  assign ultimo    = (idx_q == rodada_q);
  assign wr_en     = seq_if.carrega && (state_q == IDLE) && !reset;

`ifdef SEQ_TIMEOUT_EN
  localparam int TW = $clog2(M_TIMEOUT + 1);
  logic [TW-1:0] to_cnt_q;

  // Per-play timer: runs only in ESPERA, so leaving ESPERA clears it.
  always_ff @(posedge clock) begin
    if (reset || state_q != ESPERA) to_cnt_q <= '0;
    else                            to_cnt_q <= to_cnt_q + 1'b1;
  end

  assign to_fire = (state_q == ESPERA) && (to_cnt_q == TW'(M_TIMEOUT - 1));
`else
  assign to_fire = 1'b0;
`endif

  // Next note index; the memory read port is addressed with it so that the
  // word for a new index is already on rd_q during that index's first cycle.
  always_comb begin
    // NOTE: every variable written in always_comb gets a default first, so no
    // path through the case can leave it unassigned and infer a latch.
    idx_d = idx_q;
    if (reset) begin
      idx_d = '0;
    end else begin
      case (state_q)
        MOSTRA:  if (nota_fim)  idx_d = ultimo ? '0 : idx_q + 1'b1;
        ESPERA:  idx_d = idx_q;
        AVALIA:  if (jogada_ok) idx_d = ultimo ? '0 : idx_q + 1'b1;
        default: idx_d = '0;
      endcase
    end
  end

  // Sequence memory: writes only in IDLE, registered read with write bypass so
  // a note loaded on the start edge is the one presented.
  always_ff @(posedge clock) begin
    // NOTE: the memory has no reset branch on purpose -- reset must keep the
    // loaded sequence, and a reset-free array maps onto plain RAM.
    if (wr_en) mem_q[seq_if.carrega_addr] <= seq_if.carrega_dado;
    if (wr_en && seq_if.carrega_addr == idx_d) rd_q <= seq_if.carrega_dado;
    else                                       rd_q <= mem_q[idx_d];
  end

  // Press edge detector: tracks the button levels in every state.
  always_ff @(posedge clock) begin
    if (reset) prev_or_q <= 1'b0;
    else       prev_or_q <= any_btn;
  end

  // Game FSM with registered outputs; what a state does is visible while the
  // block is in that state (verdicts in AVALIA, round bonus in FIM_RODADA).
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before this edge regardless of order.
    if (reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      rodada_q   <= '0;
      nota_cnt_q <= '0;
      jogada_q   <= '0;
      erros_q    <= '0;
      pontos_q   <= '0;
      mostra_q   <= 1'b0;
      acertou_q  <= 1'b0;
      errou_q    <= 1'b0;
      timeout_q  <= 1'b0;
      ganhou_q   <= 1'b0;
      perdeu_q   <= 1'b0;
    end else begin
      idx_q     <= idx_d;
      acertou_q <= 1'b0;
      errou_q   <= 1'b0;
      timeout_q <= 1'b0;

      case (state_q)
        IDLE, GANHOU, PERDEU: begin
          if (seq_if.iniciar) begin
            state_q    <= MOSTRA;
            rodada_q   <= '0;
            nota_cnt_q <= '0;
            erros_q    <= '0;
            pontos_q   <= '0;
            mostra_q   <= 1'b1;
            ganhou_q   <= 1'b0;
            perdeu_q   <= 1'b0;
          end
        end

        MOSTRA: begin
          if (nota_fim) begin
            nota_cnt_q <= '0;
            if (ultimo) begin
              state_q  <= ESPERA;
              mostra_q <= 1'b0;
            end
          end else begin
            nota_cnt_q <= nota_cnt_q + 1'b1;
          end
        end

        ESPERA: begin
          if (press || to_fire) begin
            state_q  <= AVALIA;
            jogada_q <= press ? seq_if.botoes : '0;
            if (press && play_ok) begin
              acertou_q <= 1'b1;
              pontos_q  <= sat_add(pontos_q, 8'd1);
            end else begin
              errou_q   <= 1'b1;
              timeout_q <= !press;
              erros_q   <= erros_q + 4'd1;
              if (seq_if.modo) pontos_q <= floor_sub2(pontos_q);
            end
          end
        end

        AVALIA: begin
          if (jogada_ok) begin
            if (!ultimo) begin
              state_q <= ESPERA;
            end else if (rodada_q == AW'(PROF - 1)) begin
              state_q  <= GANHOU;
              ganhou_q <= 1'b1;
            end else begin
              state_q  <= FIM_RODADA;
              pontos_q <= sat_add(pontos_q, 8'(rodada_q) + 8'd1);
              rodada_q <= rodada_q + 1'b1;
            end
          end else if (!seq_if.modo || erros_q >= 4'(MAX_ERROS)) begin
            state_q  <= PERDEU;
            perdeu_q <= 1'b1;
          end else begin
            state_q <= ESPERA;
          end
        end

        FIM_RODADA: begin
          state_q    <= MOSTRA;
          nota_cnt_q <= '0;
          mostra_q   <= 1'b1;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  // Output mapping; only nota_esperada is gated rather than a plain register.
  assign seq_if.nota_esperada = mostra_q ? rd_q : '0;
  assign seq_if.mostra        = mostra_q;
  assign seq_if.acertou       = acertou_q;
  assign seq_if.errou         = errou_q;
  assign seq_if.timeout       = timeout_q;
  assign seq_if.rodada        = rodada_q;
  assign seq_if.erros         = erros_q;
  assign seq_if.pontos        = pontos_q;
  assign seq_if.ganhou        = ganhou_q;
  assign seq_if.perdeu        = perdeu_q;
  assign seq_if.db_estado     = state_q;

endmodule

// File: tb/tb_verificador_sequencia_param.sv
// Directed bench for verificador_sequencia_param with PROF=4, T_NOTA=4,
// M_TIMEOUT=20, MAX_ERROS=2, N_BOTOES=7. Inputs change 1 time unit after a
// rising edge; outputs are sampled at the same point.
module tb_verificador_sequencia_param;

  localparam int NB = 7;
  localparam int AW = 2;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_MOSTRA = 3'd1;
  localparam logic [2:0] S_ESPERA = 3'd2;
  localparam logic [2:0] S_AVALIA = 3'd3;
  localparam logic [2:0] S_FIM    = 3'd4;
  localparam logic [2:0] S_GANHOU = 3'd5;
  localparam logic [2:0] S_PERDEU = 3'd6;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_err    = 0;
  int   exp_p;

  always #5 clk = ~clk;

  verificador_sequencia_param_if #(.N_BOTOES(NB), .AW(AW)) bus ();

  verificador_sequencia_param #(
    .N_BOTOES (NB),
    .PROF     (4),
    .T_NOTA   (4),
    .M_TIMEOUT(20),
    .MAX_ERROS(2)
  ) dut (
    .clock (clk),
    .reset (rst),
    .seq_if(bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input logic [2:0] s, input string tag);
    int n;
    n = 0;
    while (bus.db_estado !== s && n < 100) begin
      tick();
      n++;
    end
    check(tag, 32'(bus.db_estado), 32'(s));
  endtask

  task automatic press(input logic [NB-1:0] b);
    bus.botoes = b;
    tick();
    bus.botoes = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic start();
    bus.iniciar = 1'b1;
    tick();
    bus.iniciar = 1'b0;
  endtask

  initial begin
    rst              = 1'b1;
    bus.carrega      = 1'b0;
    bus.carrega_addr = '0;
    bus.carrega_dado = '0;
    bus.iniciar      = 1'b0;
    bus.modo         = 1'b0;
    bus.botoes       = '0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_estado", 32'(bus.db_estado), 32'(S_IDLE));
    check("rst_mostra", 32'(bus.mostra), 0);
    check("rst_nota", 32'(bus.nota_esperada), 0);
    check("rst_pontos", 32'(bus.pontos), 0);
    check("rst_fim", 32'({bus.ganhou, bus.perdeu, bus.erros}), 0);

    // Load 01,02,04,08
    for (int i = 0; i < 4; i++) begin
      bus.carrega      = 1'b1;
      bus.carrega_addr = AW'(i);
      bus.carrega_dado = NB'(1 << i);
      tick();
    end
    bus.carrega = 1'b0;

    // Full game, strict mode, every play correct
    exp_p = 0;
    start();
    check("start_mostra", 32'(bus.mostra), 1);
    check("start_estado", 32'(bus.db_estado), 32'(S_MOSTRA));
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 4 * (r + 1); k++) begin
        check($sformatf("r%0d_nota%0d", r, k), 32'(bus.nota_esperada), 32'(1 << (k / 4)));
        check($sformatf("r%0d_mostra%0d", r, k), 32'(bus.mostra), 1);
        tick();
      end
      check($sformatf("r%0d_fim_mostra", r), 32'(bus.mostra), 0);
      check($sformatf("r%0d_espera", r), 32'(bus.db_estado), 32'(S_ESPERA));
      for (int j = 0; j <= r; j++) begin
        press(NB'(1 << j));
        exp_p++;
        check($sformatf("r%0d_acertou%0d", r, j), 32'(bus.acertou), 1);
        check($sformatf("r%0d_pontos%0d", r, j), 32'(bus.pontos), 32'(exp_p));
        tick();
      end
      if (r < 3) begin
        exp_p += r + 1;
        check($sformatf("r%0d_fim_rodada", r), 32'(bus.db_estado), 32'(S_FIM));
        check($sformatf("r%0d_bonus", r), 32'(bus.pontos), 32'(exp_p));
        check($sformatf("r%0d_rodada", r), 32'(bus.rodada), 32'(r + 1));
        tick();
      end
    end
    check("ganhou", 32'(bus.ganhou), 1);
    check("ganhou_estado", 32'(bus.db_estado), 32'(S_GANHOU));
    check("ganhou_pontos", 32'(bus.pontos), 16);
    tick();
    check("ganhou_hold", 32'(bus.ganhou), 1);

    // Strict mode, wrong note in round 0
    bus.modo = 1'b0;
    start();
    check("strict_ganhou_clr", 32'(bus.ganhou), 0);
    check("strict_pontos_clr", 32'(bus.pontos), 0);
    wait_state(S_ESPERA, "strict_wait");
    press(7'h02);
    check("strict_errou", 32'(bus.errou), 1);
    check("strict_acertou", 32'(bus.acertou), 0);
    check("strict_erros", 32'(bus.erros), 1);
    check("strict_pontos", 32'(bus.pontos), 0);
    tick();
    check("strict_perdeu", 32'(bus.perdeu), 1);
    check("strict_estado", 32'(bus.db_estado), 32'(S_PERDEU));
    check("strict_errou_pulse", 32'(bus.errou), 0);

    // Tolerant mode, retry of a wrong note in round 1
    bus.modo = 1'b1;
    start();
    check("tol_perdeu_clr", 32'(bus.perdeu), 0);
    check("tol_erros_clr", 32'(bus.erros), 0);
    wait_state(S_ESPERA, "tol_wait0");
    press(7'h01);
    check("tol_p1", 32'(bus.pontos), 1);
    tick();
    check("tol_p2_bonus", 32'(bus.pontos), 2);
    wait_state(S_ESPERA, "tol_wait1");
    press(7'h01);
    check("tol_p3", 32'(bus.pontos), 3);
    tick();
    press(7'h04);
    check("tol_errou", 32'(bus.errou), 1);
    check("tol_erros", 32'(bus.erros), 1);
    check("tol_p_penalty", 32'(bus.pontos), 1);
    tick();
    check("tol_retry_estado", 32'(bus.db_estado), 32'(S_ESPERA));
    press(7'h02);
    check("tol_retry_ok", 32'(bus.acertou), 1);
    check("tol_p_retry", 32'(bus.pontos), 2);
    tick();
    check("tol_fim_rodada", 32'(bus.db_estado), 32'(S_FIM));
    check("tol_p_bonus2", 32'(bus.pontos), 4);
    check("tol_rodada", 32'(bus.rodada), 2);
    check("tol_erros_keep", 32'(bus.erros), 1);

    // Timeout in tolerant mode
    do_reset();
    bus.modo = 1'b1;
    start();
    wait_state(S_ESPERA, "to_wait");
`ifdef SEQ_TIMEOUT_EN
    for (int i = 0; i < 19; i++) tick();
    check("to_early", 32'(bus.timeout), 0);
    check("to_early_estado", 32'(bus.db_estado), 32'(S_ESPERA));
    tick();
    check("to_fire1", 32'(bus.timeout), 1);
    check("to_errou1", 32'(bus.errou), 1);
    check("to_erros1", 32'(bus.erros), 1);
    tick();
    check("to_retry", 32'(bus.db_estado), 32'(S_ESPERA));
    for (int i = 0; i < 20; i++) tick();
    check("to_fire2", 32'(bus.timeout), 1);
    check("to_erros2", 32'(bus.erros), 2);
    tick();
    check("to_perdeu", 32'(bus.perdeu), 1);
`else
    for (int i = 0; i < 20; i++) tick();
    check("noto_timeout", 32'(bus.timeout), 0);
    check("noto_errou", 32'(bus.errou), 0);
    check("noto_estado", 32'(bus.db_estado), 32'(S_ESPERA));
    for (int i = 0; i < 40; i++) tick();
    check("noto_still", 32'(bus.db_estado), 32'(S_ESPERA));
    check("noto_erros", 32'(bus.erros), 0);
`endif

    // Multi-hot play, then a button held from MOSTRA into ESPERA
    do_reset();
    bus.modo = 1'b1;
    start();
    wait_state(S_ESPERA, "mh_wait");
    press(7'h03);
    check("mh_errou", 32'(bus.errou), 1);
    check("mh_acertou", 32'(bus.acertou), 0);
    tick();
    check("mh_retry", 32'(bus.db_estado), 32'(S_ESPERA));
    bus.botoes = 7'h01;
    tick();
    check("hold_first_ok", 32'(bus.acertou), 1);
    wait_state(S_ESPERA, "hold_wait");
    for (int i = 0; i < 5; i++) begin
      check($sformatf("hold_noverdict%0d", i), 32'({bus.acertou, bus.errou}), 0);
      check($sformatf("hold_estado%0d", i), 32'(bus.db_estado), 32'(S_ESPERA));
      tick();
    end
    bus.botoes = '0;
    tick();
    press(7'h01);
    check("hold_repress_ok", 32'(bus.acertou), 1);
    check("hold_pontos", 32'(bus.pontos), 3);

    // Reset in the middle of MOSTRA, then replay of the stored sequence
    do_reset();
    start();
    tick();
    tick();
    check("mid_mostra", 32'(bus.db_estado), 32'(S_MOSTRA));
    rst = 1'b1;
    tick();
    check("mid_rst_estado", 32'(bus.db_estado), 32'(S_IDLE));
    check("mid_rst_mostra", 32'(bus.mostra), 0);
    check("mid_rst_nota", 32'(bus.nota_esperada), 0);
    check("mid_rst_outs", 32'({bus.pontos, bus.erros, bus.rodada, bus.ganhou, bus.perdeu}), 0);
    rst = 1'b0;
    start();
    check("replay_nota", 32'(bus.nota_esperada), 32'h01);
    check("replay_mostra", 32'(bus.mostra), 1);

    // Load together with start is honoured; load during MOSTRA is ignored
    do_reset();
    bus.carrega      = 1'b1;
    bus.carrega_addr = 2'd0;
    bus.carrega_dado = 7'h10;
    start();
    bus.carrega_addr = 2'd1;
    bus.carrega_dado = 7'h40;
    check("ld_start_nota", 32'(bus.nota_esperada), 32'h10);
    tick();
    bus.carrega = 1'b0;
    wait_state(S_ESPERA, "ld_wait");
    press(7'h10);
    check("ld_acertou", 32'(bus.acertou), 1);
    tick();
    tick();
    for (int i = 0; i < 4; i++) tick();
    check("ld_ignored_nota", 32'(bus.nota_esperada), 32'h02);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
